// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding, default timeout and error-data constants.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEF_ERR_DATA       = 32'h0000_0000;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and its responder.
// The master holds addr/we/wdata stable while req is high; the slave returns ack with rdata.
interface mem_access_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// 8-bit wait counter for the REQ state; expired is high on the last permitted REQ cycle.
// Count starts at 0 on the first REQ cycle, so expiry lands on cycle TIMEOUT_CYCLES.
module mem_wait_timer
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one bus transaction per load/store,
// stalls the pipeline until DONE, holds load data, flags misalignment and bus timeouts.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_read_mem,
    input  logic                     mem_write_mem,
    input  logic [31:0]              alu_result_mem,
    input  logic [31:0]              data2_mem,
    mem_access_ctrl_if.master        bus,
    output logic                     stall_mem,
    output logic [31:0]              read_data_mem,
    output logic                     mem_error,
    output logic                     error_sticky
);

    state_t state;
    logic   abort;
    logic   load_q;
    logic   op;
    logic   misaligned;
    logic   is_load;
    logic   tmr_expired;

    assign op         = mem_read_mem | mem_write_mem;
    assign misaligned = |alu_result_mem[1:0];
    assign is_load    = mem_read_mem & ~mem_write_mem;

    // Gated by reset so the pipeline is never frozen while the controller is held in reset.
    assign stall_mem = reset & (((state == ST_IDLE) & op) | (state == ST_REQ));

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (state == ST_IDLE),
        .en     (state == ST_REQ),
        .expired(tmr_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            abort         <= 1'b0;
            load_q        <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            read_data_mem <= '0;
            mem_error     <= 1'b0;
            error_sticky  <= 1'b0;
        end else begin
            mem_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op) begin
                        load_q <= is_load;
                        if (misaligned) begin
                            abort     <= 1'b1;
                            mem_error <= 1'b1;
                            if (is_load) begin
                                read_data_mem <= ERR_DATA;
                            end
                            state <= ST_DONE;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_write_mem;
                            bus.bus_addr  <= word_addr(alu_result_mem);
                            bus.bus_wdata <= data2_mem;
                            state         <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack on the expiry cycle still completes the transfer normally.
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (load_q) begin
                            read_data_mem <= bus.bus_rdata;
                        end
                        state <= ST_DONE;
                    end else if (tmr_expired) begin
                        bus.bus_req <= 1'b0;
                        abort       <= 1'b1;
                        mem_error   <= 1'b1;
                        if (load_q) begin
                            read_data_mem <= ERR_DATA;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    error_sticky <= error_sticky | abort;
                    abort        <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Transaction-level reference model drives per-cycle expectations; one negedge compare loop checks them.
module tb_mem_access_ctrl;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] data2_mem;
    logic        stall_mem;
    logic [31:0] read_data_mem;
    logic        mem_error;
    logic        error_sticky;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (ERR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read_mem  (mem_read_mem),
        .mem_write_mem (mem_write_mem),
        .alu_result_mem(alu_result_mem),
        .data2_mem     (data2_mem),
        .bus           (bus),
        .stall_mem     (stall_mem),
        .read_data_mem (read_data_mem),
        .mem_error     (mem_error),
        .error_sticky  (error_sticky)
    );

    always #5 clock = ~clock;

    int n_checks;
    int n_fail;

    // Architectural model state: what the outputs must hold between transactions.
    logic        m_we, m_sticky;
    logic [31:0] m_addr, m_wdata, m_rd;

    // Expected outputs for the current cycle.
    logic        exp_stall, exp_req, exp_we, exp_err, exp_sticky;
    logic [31:0] exp_addr, exp_wdata, exp_rd;

    int tot_stall, tot_req, tot_err;
    int base_stall, base_req, base_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_hold_exp(input logic stall);
        exp_stall  = stall;
        exp_req    = 1'b0;
        exp_we     = m_we;
        exp_addr   = m_addr;
        exp_wdata  = m_wdata;
        exp_rd     = m_rd;
        exp_err    = 1'b0;
        exp_sticky = m_sticky;
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0; m_sticky = 1'b0;
        set_hold_exp(1'b0);
    endtask

    task automatic mark();
        base_stall = tot_stall;
        base_req   = tot_req;
        base_err   = tot_err;
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int ack_delay, input logic [31:0] rdata);
        logic op, load, mis, abort;
        int   n_req;
        op    = rd | wr;
        load  = rd & ~wr;
        mis   = (addr[1:0] != 2'b00);
        abort = mis || (ack_delay >= TMO);
        n_req = mis ? 0 : (abort ? TMO : ack_delay + 1);
        @(posedge clock); #1;
        mem_read_mem   = rd;
        mem_write_mem  = wr;
        alu_result_mem = addr;
        data2_mem      = data;
        bus.bus_ack    = 1'($urandom);
        bus.bus_rdata  = $urandom;
        set_hold_exp(op);
        if (!op) return;
        if (!mis) begin
            m_we    = wr;
            m_addr  = {addr[31:2], 2'b00};
            m_wdata = data;
        end
        for (int t = 1; t <= n_req; t++) begin
            @(posedge clock); #1;
            bus.bus_ack   = (t == ack_delay + 1);
            bus.bus_rdata = (t == ack_delay + 1) ? rdata : $urandom;
            exp_stall = 1'b1;
            exp_req   = 1'b1;
            exp_we    = m_we;
            exp_addr  = m_addr;
            exp_wdata = m_wdata;
        end
        @(posedge clock); #1;
        bus.bus_ack   = 1'($urandom);
        bus.bus_rdata = $urandom;
        if (load) m_rd = abort ? ERR : rdata;
        set_hold_exp(1'b0);
        exp_err  = abort;
        m_sticky = m_sticky | abort;
    endtask

    task automatic settle();
        @(negedge clock); #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        tot_stall = 0; tot_req = 0; tot_err = 0;
        base_stall = 0; base_req = 0; base_err = 0;
        reset = 1'b0;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        alu_result_mem = '0; data2_mem = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        model_reset();
        fork
            begin : driver
                repeat (2) @(posedge clock);
                #1 reset = 1'b1;
                run_op(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
                settle();

                mark();
                run_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D);
                settle();
                check("load_stall_cycles", 32'(tot_stall - base_stall), 32'd2);
                check("load_req_cycles", 32'(tot_req - base_req), 32'd1);
                check("load_no_error", 32'(tot_err - base_err), 32'd0);
                check("load_rdata", read_data_mem, 32'hCAFE_F00D);
                check("load_addr", bus.bus_addr, 32'h0000_0010);
                check("load_we", bus.bus_we, 32'd0);

                mark();
                run_op(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'h0);
                settle();
                check("store_stall_cycles", 32'(tot_stall - base_stall), 32'd5);
                check("store_we", bus.bus_we, 32'd1);
                check("store_wdata", bus.bus_wdata, 32'h1234_5678);
                check("store_rdata_held", read_data_mem, 32'hCAFE_F00D);

                mark();
                run_op(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0);
                settle();
                check("mis_stall_cycles", 32'(tot_stall - base_stall), 32'd1);
                check("mis_no_req", 32'(tot_req - base_req), 32'd0);
                check("mis_error_pulse", 32'(tot_err - base_err), 32'd1);
                check("mis_rdata", read_data_mem, ERR);
                run_op(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
                settle();
                check("mis_sticky", error_sticky, 32'd1);

                run_op(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1, 32'hA5A5_5A5A);
                mark();
                run_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 99, 32'h0);
                settle();
                check("tmo_req_cycles", 32'(tot_req - base_req), 32'd4);
                check("tmo_stall_cycles", 32'(tot_stall - base_stall), 32'd5);
                check("tmo_error_pulse", 32'(tot_err - base_err), 32'd1);
                check("tmo_rdata", read_data_mem, ERR);

                run_op(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 32'hA5A5_5A5A);
                run_op(1'b1, 1'b1, 32'h0000_0050, 32'h0BAD_C0DE, 1, 32'h7777_7777);
                settle();
                check("both_we", bus.bus_we, 32'd1);
                check("both_rdata_held", read_data_mem, 32'hA5A5_5A5A);

                // Reset lands in the second REQ cycle of a store.
                @(posedge clock); #1;
                mem_read_mem = 1'b0; mem_write_mem = 1'b1;
                alu_result_mem = 32'h0000_0060; data2_mem = 32'h55AA_55AA;
                bus.bus_ack = 1'b0;
                set_hold_exp(1'b1);
                m_we = 1'b1; m_addr = 32'h0000_0060; m_wdata = 32'h55AA_55AA;
                repeat (2) begin
                    @(posedge clock); #1;
                    bus.bus_ack = 1'b0;
                    exp_stall = 1'b1; exp_req = 1'b1;
                    exp_we = m_we; exp_addr = m_addr; exp_wdata = m_wdata;
                end
                #1 reset = 1'b0;
                model_reset();
                #1;
                check("rst_async_req_drop", bus.bus_req, 32'd0);
                check("rst_stall_low", stall_mem, 32'd0);
                @(posedge clock); #1;
                mem_write_mem = 1'b0;
                @(posedge clock); #1;
                reset = 1'b1;
                settle();
                check("rst_sticky_cleared", error_sticky, 32'd0);
                check("rst_rdata_cleared", read_data_mem, 32'd0);
                mark();
                run_op(1'b1, 1'b0, 32'h0000_0070, 32'h0, 1, 32'h600D_F00D);
                settle();
                check("post_rst_stall_cycles", 32'(tot_stall - base_stall), 32'd3);
                check("post_rst_rdata", read_data_mem, 32'h600D_F00D);

                for (int i = 0; i < 300; i++) begin
                    int          kind;
                    logic [31:0] a;
                    kind = $urandom_range(0, 9);
                    a    = $urandom;
                    if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                    run_op(kind inside {[3:5], 9}, kind inside {[6:9]}, a, $urandom,
                           $urandom_range(0, 5), $urandom);
                end
                run_op(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
                settle();
            end
            forever begin
                @(negedge clock);
                check("stall_mem", stall_mem, exp_stall);
                check("bus_req", bus.bus_req, exp_req);
                check("bus_we", bus.bus_we, exp_we);
                check("bus_addr", bus.bus_addr, exp_addr);
                check("bus_wdata", bus.bus_wdata, exp_wdata);
                check("read_data_mem", read_data_mem, exp_rd);
                check("mem_error", mem_error, exp_err);
                check("error_sticky", error_sticky, exp_sticky);
                if (stall_mem === 1'b1) tot_stall++;
                if (bus.bus_req === 1'b1) tot_req++;
                if (mem_error === 1'b1) tot_err++;
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
